// File: rtl/miner_host_bridge_pkg.sv
// Shared widths and FSM state type for the miner host bridge.
// Imported by the bridge, its counters and its testbench.
package miner_pkg;

    localparam int TARGET_BITS = 256;
    localparam int NONCE_BITS  = 32;
    localparam int BLOCK_BITS  = 608;
    localparam int WORK_BITS   = BLOCK_BITS + TARGET_BITS;
    localparam int RESULT_BITS = TARGET_BITS + NONCE_BITS;
    localparam int CNT_W       = 7;

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        SEND
    } bridge_state_t;

endpackage

// File: rtl/miner_host_bridge_if.sv
// Byte-level host link: work bytes in, result bytes out.
// Both directions use a valid/ready handshake.
interface miner_host_bridge_if;

    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  out_byte,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output out_byte,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/miner_host_bridge_byte_counter.sv
// Byte position counter with clear, enable and terminal-count flag.
// Clear wins over enable so a wrap never shows a stale count.
module miner_byte_counter
    import miner_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/miner_host_bridge.sv
// Assembles 108-byte work packets for the miner and streams
// each 36-byte result back to the host.
module miner_host_bridge
    import miner_pkg::*;
#(
    parameter int WORK_BYTES   = 108,
    parameter int RESULT_BYTES = 36
)
(
    input  logic                   clk,
    input  logic                   rst,
    miner_host_bridge_if.slave     link,
    output logic [WORK_BITS-1:0]   rx_data,
    output logic                   data_ready,
    input  logic                   send_data,
    input  logic [RESULT_BITS-1:0] tx_data,
    output logic                   busy,
    output logic                   overrun
);

    bridge_state_t state_q;
    bridge_state_t state_d;

    logic [WORK_BITS-1:0]   asm_q;
    logic [WORK_BITS-1:0]   asm_next;
    logic [WORK_BITS-1:0]   rx_q;
    logic [RESULT_BITS-1:0] res_q;
    logic                   dr_q;
    logic                   ovr_q;

    logic             w_clr;
    logic             w_en;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt;
    logic             r_clr;
    logic             r_en;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;

    logic in_fire;
    logic out_fire;
    logic capture;

    miner_byte_counter u_work_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_en),
        .term    (CNT_W'(WORK_BYTES - 1)),
        .count   (w_cnt),
        .at_term (w_last)
    );

    miner_byte_counter u_res_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_clr),
        .en      (r_en),
        .term    (CNT_W'(RESULT_BYTES - 1)),
        .count   (r_cnt),
        .at_term (r_last)
    );

    assign in_fire  = (state_q == LOAD) && link.in_valid;
    assign out_fire = (state_q == SEND) && link.out_ready;
    assign capture  = (state_q == WAIT) && send_data;
    assign asm_next = {asm_q[WORK_BITS-9:0], link.in_byte};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        link.in_ready  = 1'b0;
        link.out_valid = 1'b0;
        link.out_byte  = '0;
        w_clr          = 1'b0;
        w_en           = 1'b0;
        r_clr          = 1'b0;
        r_en           = 1'b0;
        unique case (state_q)
            LOAD: begin
                link.in_ready = 1'b1;
                if (link.in_valid) begin
                    if (w_last) begin
                        w_clr   = 1'b1;
                        state_d = WAIT;
                    end else begin
                        w_en = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (send_data) begin
                    r_clr   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                link.out_valid = 1'b1;
                link.out_byte  = res_q[RESULT_BITS-1 -: 8];
                if (link.out_ready) begin
                    if (r_last) begin
                        r_clr   = 1'b1;
                        state_d = LOAD;
                    end else begin
                        r_en = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // rx_q is only written on the final work byte: the miner
    // reads it for the whole search.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
            rx_q  <= '0;
            res_q <= '0;
            dr_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            dr_q  <= 1'b0;
            ovr_q <= send_data && (state_q != WAIT);
            if (in_fire) begin
                asm_q <= asm_next;
                if (w_last) begin
                    rx_q <= asm_next;
                    dr_q <= 1'b1;
                end
            end
            if (capture) begin
                res_q <= tx_data;
            end else if (out_fire) begin
                res_q <= {res_q[RESULT_BITS-9:0], 8'h00};
            end
        end
    end

    assign rx_data    = rx_q;
    assign data_ready = dr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != LOAD);

endmodule

// File: tb/tb_miner_host_bridge.sv
// Directed bench for miner_host_bridge: packets, results,
// backpressure, overruns and mid-operation resets.
module tb_miner_host_bridge;
    import miner_pkg::*;

    typedef logic [WORK_BITS-1:0]   w_t;
    typedef logic [RESULT_BITS-1:0] r_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    w_t   rx_data;
    logic data_ready;
    logic send_data = 1'b0;
    r_t   tx_data = '0;
    logic busy;
    logic overrun;

    int passed  = 0;
    int total   = 0;
    int dr_cnt  = 0;
    int ovr_cnt = 0;

    miner_host_bridge_if link();

    miner_host_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .link       (link),
        .rx_data    (rx_data),
        .data_ready (data_ready),
        .send_data  (send_data),
        .tx_data    (tx_data),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_ready) dr_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic w_t work_word(input logic [7:0] start);
        w_t w;
        w = '0;
        for (int i = 0; i < 108; i++) begin
            w[WORK_BITS-1-8*i -: 8] = start + 8'(i);
        end
        return w;
    endfunction

    task automatic send_work(input logic [7:0] start, input int nbytes,
                             input int gap_mod, input int ovr_at);
        for (int i = 0; i < nbytes; i++) begin
            link.in_byte  = start + 8'(i);
            link.in_valid = 1'b1;
            send_data     = (i == ovr_at);
            tick();
            send_data     = 1'b0;
            link.in_valid = 1'b0;
            if (gap_mod > 0 && i % gap_mod == 0 && i != nbytes - 1) begin
                link.in_byte = 8'hA5;
                tick();
            end
        end
    endtask

    task automatic recv(input r_t tx, input r_t junk, input bit toggle,
                        input int inj_cyc, input int abort_at,
                        output r_t got, output int n);
        logic [7:0] prev;
        bit stalled;
        int bad;
        tx_data   = tx;
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
        tx_data   = junk;
        chk("cap_valid", w_t'(link.out_valid), w_t'(1));
        chk("cap_first", w_t'(link.out_byte), w_t'(tx[RESULT_BITS-1 -: 8]));
        got = '0;
        n = 0;
        bad = 0;
        stalled = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 400 && n < 36 && n != abort_at; cyc++) begin
            if (stalled && link.out_byte !== prev) bad++;
            link.out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            send_data = (cyc == inj_cyc);
            stalled = link.out_valid && !link.out_ready;
            prev = link.out_byte;
            if (link.out_valid && link.out_ready) begin
                got = {got[RESULT_BITS-9:0], link.out_byte};
                n++;
            end
            tick();
            send_data = 1'b0;
        end
        link.out_ready = 1'b0;
        chk("stall_stable", w_t'(bad), w_t'(0));
    endtask

    initial begin
        r_t got;
        int n;
        int ovr0;
        w_t held;
        r_t tx1;
        r_t tx2;
        tx1 = {{4{64'h0123456789ABCDEF}}, 32'hDEADBEEF};
        tx2 = {{256{1'b1}}, 32'h0};
        link.in_byte   = '0;
        link.in_valid  = 1'b0;
        link.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", w_t'(link.in_ready), w_t'(1));
        chk("rst_out_valid", w_t'(link.out_valid), w_t'(0));
        chk("rst_out_byte", w_t'(link.out_byte), w_t'(0));
        chk("rst_rx_data", rx_data, w_t'(0));
        chk("rst_data_ready", w_t'(data_ready), w_t'(0));
        chk("rst_busy", w_t'(busy), w_t'(0));
        chk("rst_overrun", w_t'(overrun), w_t'(0));
        rst = 1'b0;

        // Full packet 0x00..0x6B back-to-back
        send_work(8'h00, 108, 0, -1);
        chk("pkt1_dr", w_t'(data_ready), w_t'(1));
        chk("pkt1_rx", rx_data, work_word(8'h00));
        chk("pkt1_first", w_t'(rx_data[863:856]), w_t'(8'h00));
        chk("pkt1_last", w_t'(rx_data[7:0]), w_t'(8'h6B));
        chk("pkt1_in_ready", w_t'(link.in_ready), w_t'(0));
        chk("pkt1_busy", w_t'(busy), w_t'(1));
        held = rx_data;
        link.in_valid = 1'b1;
        link.in_byte  = 8'hFF;
        repeat (3) tick();
        link.in_valid = 1'b0;
        chk("pkt1_dr_once", w_t'(dr_cnt), w_t'(1));
        chk("wait_rx_held", rx_data, held);
        chk("wait_in_ready", w_t'(link.in_ready), w_t'(0));

        // Result stream, host always ready
        ovr0 = ovr_cnt;
        recv(tx1, '0, 1'b0, -1, -1, got, n);
        chk("res1_count", w_t'(n), w_t'(36));
        chk("res1_bytes", w_t'(got), w_t'(tx1));
        chk("res1_head", w_t'(got[287:280]), w_t'(8'h01));
        chk("res1_tail", w_t'(got[31:0]), w_t'(32'hDEADBEEF));
        chk("res1_in_ready", w_t'(link.in_ready), w_t'(1));
        chk("res1_out_valid", w_t'(link.out_valid), w_t'(0));
        chk("res1_busy", w_t'(busy), w_t'(0));
        chk("res1_no_ovr", w_t'(ovr_cnt - ovr0), w_t'(0));

        // Gapped packet with a dropped send_data at byte 50
        ovr0 = ovr_cnt;
        send_work(8'h40, 108, 3, 50);
        chk("pkt2_dr", w_t'(data_ready), w_t'(1));
        chk("pkt2_rx", rx_data, work_word(8'h40));
        tick();
        chk("pkt2_ovr", w_t'(ovr_cnt - ovr0), w_t'(1));
        chk("pkt2_dr_cnt", w_t'(dr_cnt), w_t'(2));

        // No-nonce result, toggling backpressure, dropped pulse in SEND
        ovr0 = ovr_cnt;
        recv(tx2, {8{36'h123456789}}, 1'b1, 5, -1, got, n);
        chk("res2_count", w_t'(n), w_t'(36));
        chk("res2_bytes", w_t'(got), w_t'(tx2));
        chk("res2_ff", w_t'(got[287:32]), w_t'({256{1'b1}}));
        chk("res2_zero", w_t'(got[31:0]), w_t'(0));
        chk("res2_ovr", w_t'(ovr_cnt - ovr0), w_t'(1));
        chk("res2_in_ready", w_t'(link.in_ready), w_t'(1));

        // Reset after 60 work bytes
        send_work(8'h10, 60, 0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst60_in_ready", w_t'(link.in_ready), w_t'(1));
        chk("rst60_rx", rx_data, w_t'(0));
        chk("rst60_busy", w_t'(busy), w_t'(0));
        send_work(8'h90, 108, 4, -1);
        chk("pkt3_dr", w_t'(data_ready), w_t'(1));
        chk("pkt3_rx", rx_data, work_word(8'h90));

        // Reset during result byte 10
        recv(tx1, '0, 1'b0, -1, 10, got, n);
        chk("abort_count", w_t'(n), w_t'(10));
        chk("abort_part", w_t'(got[79:0]), w_t'(tx1[287:208]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", w_t'(link.out_valid), w_t'(0));
        chk("abort_out_byte", w_t'(link.out_byte), w_t'(0));
        chk("abort_busy", w_t'(busy), w_t'(0));
        chk("abort_in_ready", w_t'(link.in_ready), w_t'(1));
        chk("abort_rx", rx_data, w_t'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
